// File: rtl/vector_lane_sequencer_pkg.sv
// Shared types and helpers for the vector lane sequencer.
// State encoding, FP function codes, and the partial-group lane mask.
package vseq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        WRITE,
        DONE
    } vseq_state_e;

    localparam logic FUNC_ADD = 1'b0;
    localparam logic FUNC_MUL = 1'b1;

    // Mask for the last group: rem lanes active, rem == 0 means a full group.
    // Returned wide; callers truncate to their lane count.
    function automatic logic [31:0] last_mask(input logic [31:0] rem);
        if (rem == 32'd0) return '1;
        return (32'd1 << rem) - 32'd1;
    endfunction

endpackage

// File: rtl/vector_lane_sequencer_if.sv
// Command, lane-issue and write-back bus of the vector lane sequencer.
// master = sequencer side, slave = decode / lane array / register file side.
interface vector_lane_sequencer_if #(
    parameter int LANES      = 4,
    parameter int MAX_GROUPS = 8,
    parameter int LEN_W      = 6
);
    localparam int GRP_W = $clog2(MAX_GROUPS);

    logic             cmd_valid;
    logic             cmd_ready;
    logic             cmd_func;
    logic [LEN_W-1:0] cmd_len;
    logic             lane_start;
    logic             lane_func;
    logic [LANES-1:0] lane_en;
    logic [GRP_W-1:0] grp_idx;
    logic [LANES-1:0] lane_ready;
    logic             wb_valid;
    logic [GRP_W-1:0] wb_grp;
    logic [LANES-1:0] wb_mask;

    modport master (
        input  cmd_valid, cmd_func, cmd_len, lane_ready,
        output cmd_ready, lane_start, lane_func, lane_en, grp_idx,
               wb_valid, wb_grp, wb_mask
    );

    modport slave (
        output cmd_valid, cmd_func, cmd_len, lane_ready,
        input  cmd_ready, lane_start, lane_func, lane_en, grp_idx,
               wb_valid, wb_grp, wb_mask
    );

endinterface

// File: rtl/vector_lane_sequencer_ready.sv
// vseq_ready_collector: sticky per-lane completion mask for one group.
// Cleared while the group is issued, accumulates only while sampling,
// and reports when every enabled lane has finished (including this cycle).
module vseq_ready_collector #(
    parameter int LANES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             sample,
    input  logic [LANES-1:0] lane_ready,
    input  logic [LANES-1:0] lane_en,
    output logic             all_done
);
    logic [LANES-1:0] done_mask;
    logic [LANES-1:0] hit;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        assign hit[i] = lane_ready[i] & lane_en[i];

        // Per-lane sticky flag; disabled lanes never set it.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)      done_mask[i] <= 1'b0;
            else if (clr)    done_mask[i] <= 1'b0;
            else if (sample) done_mask[i] <= done_mask[i] | hit[i];
        end
    end

    assign all_done = ((done_mask | hit) == lane_en);

endmodule

// File: rtl/vector_lane_sequencer.sv
// vector_lane_sequencer: splits one vector add/mul command into lane groups,
// issues each group, waits for all active lanes, then strobes write-back.
// Optional macro VSEQ_PERF_CNT_EN adds busy-cycle and completed-op counters.
module vector_lane_sequencer
    import vseq_pkg::*;
#(
    parameter int LANES      = 4,
    parameter int MAX_GROUPS = 8,
    parameter int LEN_W      = 6
) (
    input  logic  clk,
    input  logic  rst_n,
    vector_lane_sequencer_if.master bus,
    input  logic  abort,
    output logic  done,
    output logic  err_len,
    output logic  aborted
`ifdef VSEQ_PERF_CNT_EN
    ,
    output logic [31:0] perf_busy_cyc,
    output logic [15:0] perf_ops
`endif
);
    localparam int GRP_W   = $clog2(MAX_GROUPS);
    localparam int MAX_LEN = LANES * MAX_GROUPS;

    vseq_state_e      state, state_n;
    logic             func_q;
    logic [LEN_W-1:0] len_q;
    logic [GRP_W-1:0] grp_q;
    logic             err_q, abt_q;

    logic             accept, busy, clamp, is_last, all_done;
    logic [LEN_W-1:0] len_m1;
    logic [GRP_W-1:0] last_grp;
    logic [LANES-1:0] grp_mask;

    assign accept   = (state == IDLE) && bus.cmd_valid;
    assign busy     = (state == ISSUE) || (state == WAIT) || (state == WRITE);
    assign clamp    = bus.cmd_len > LEN_W'(MAX_LEN);
    assign len_m1   = len_q - LEN_W'(1);
    assign last_grp = GRP_W'(len_m1 / LEN_W'(LANES));
    assign is_last  = (grp_q == last_grp);
    assign grp_mask = is_last ? LANES'(last_mask(32'(len_q % LEN_W'(LANES)))) : '1;

    assign bus.cmd_ready  = (state == IDLE);
    assign bus.lane_start = (state == ISSUE);
    assign bus.lane_func  = func_q;
    assign bus.lane_en    = busy ? grp_mask : '0;
    assign bus.grp_idx    = grp_q;
    assign bus.wb_valid   = (state == WRITE) && !abort;
    assign bus.wb_grp     = bus.wb_valid ? grp_q : '0;
    assign bus.wb_mask    = bus.wb_valid ? grp_mask : '0;
    assign done           = (state == DONE);
    assign err_len        = err_q;
    assign aborted        = abt_q;

    vseq_ready_collector #(.LANES(LANES)) u_rdy (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (state == ISSUE),
        .sample     (state == WAIT),
        .lane_ready (bus.lane_ready),
        .lane_en    (bus.lane_en),
        .all_done   (all_done)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    // Next state: abort drops straight back to IDLE from any active state.
    always_comb begin
        state_n = state;
        case (state)
            IDLE:  if (bus.cmd_valid) state_n = (bus.cmd_len == '0) ? DONE : ISSUE;
            ISSUE: state_n = abort ? IDLE : WAIT;
            WAIT:  if (abort) state_n = IDLE;
                   else if (all_done) state_n = WRITE;
            WRITE: if (abort) state_n = IDLE;
                   else state_n = is_last ? DONE : ISSUE;
            DONE:  state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Command latch, group counter and one-shot status flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            func_q <= FUNC_ADD;
            len_q  <= '0;
            grp_q  <= '0;
            err_q  <= 1'b0;
            abt_q  <= 1'b0;
        end else begin
            err_q <= 1'b0;
            abt_q <= busy && abort;
            if (accept) begin
                func_q <= bus.cmd_func;
                len_q  <= clamp ? LEN_W'(MAX_LEN) : bus.cmd_len;
                grp_q  <= '0;
                err_q  <= clamp;
            end else if ((state == WRITE) && !abort && !is_last) begin
                grp_q <= grp_q + GRP_W'(1);
            end
        end
    end

`ifdef VSEQ_PERF_CNT_EN
    // Busy cycles saturate; completed ops wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_busy_cyc <= '0;
            perf_ops      <= '0;
        end else begin
            if ((state != IDLE) && (perf_busy_cyc != '1))
                perf_busy_cyc <= perf_busy_cyc + 32'd1;
            if (state == DONE)
                perf_ops <= perf_ops + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_vector_lane_sequencer.sv
// Directed bench for vector_lane_sequencer: inputs driven 1 time unit after
// the rising edge, outputs recorded by a monitor on the falling edge.
module tb_vector_lane_sequencer;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic abort = 1'b0;
    logic done, err_len, aborted;
`ifdef VSEQ_PERF_CNT_EN
    logic [31:0] perf_busy_cyc;
    logic [15:0] perf_ops;
`endif

    always #5 clk = ~clk;

    vector_lane_sequencer_if #(.LANES(4), .MAX_GROUPS(8), .LEN_W(6)) bus();

    vector_lane_sequencer #(.LANES(4), .MAX_GROUPS(8), .LEN_W(6)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus),
        .abort   (abort),
        .done    (done),
        .err_len (err_len),
        .aborted (aborted)
`ifdef VSEQ_PERF_CNT_EN
        ,
        .perf_busy_cyc (perf_busy_cyc),
        .perf_ops      (perf_ops)
`endif
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Lane model: all lanes ready for one cycle, lat cycles after lane_start.
    logic       auto_en = 1'b0;
    int         lat = 1;
    int         rdy_at = -1;
    logic [3:0] auto_rdy = 4'h0;
    logic [3:0] man_rdy = 4'h0;
    assign bus.lane_ready = auto_rdy | man_rdy;

    always @(posedge clk) begin
        #1;
        auto_rdy = 4'h0;
        if (!auto_en) rdy_at = -1;
        else begin
            if (bus.lane_start) rdy_at = cyc + lat;
            if (cyc == rdy_at) auto_rdy = 4'hF;
        end
    end

    // Event monitor.
    int         n_start = 0, n_wb = 0, n_done = 0, n_err = 0, n_abt = 0;
    int         done_cyc = 0, err_cyc = 0, abt_cyc = 0;
    int         start_cyc [64];
    logic [3:0] start_en  [64];
    logic [2:0] start_grp [64];
    int         wb_cyc    [64];
    logic [2:0] wb_grp_a  [64];
    logic [3:0] wb_mask_a [64];
    logic       wb_func_a [64];

    always @(negedge clk) begin
        if (bus.lane_start && n_start < 64) begin
            start_cyc[n_start] <= cyc;
            start_en[n_start]  <= bus.lane_en;
            start_grp[n_start] <= bus.grp_idx;
            n_start <= n_start + 1;
        end
        if (bus.wb_valid && n_wb < 64) begin
            wb_cyc[n_wb]    <= cyc;
            wb_grp_a[n_wb]  <= bus.wb_grp;
            wb_mask_a[n_wb] <= bus.wb_mask;
            wb_func_a[n_wb] <= bus.lane_func;
            n_wb <= n_wb + 1;
        end
        if (done)    begin n_done <= n_done + 1; done_cyc <= cyc; end
        if (err_len) begin n_err  <= n_err + 1;  err_cyc  <= cyc; end
        if (aborted) begin n_abt  <= n_abt + 1;  abt_cyc  <= cyc; end
    end

    function automatic logic [20:0] out_vec();
        return {bus.cmd_ready, bus.lane_start, bus.lane_func, bus.lane_en, bus.grp_idx,
                bus.wb_valid, bus.wb_grp, bus.wb_mask, done, err_len, aborted};
    endfunction

    task automatic send(input logic f, input logic [5:0] l, output int t);
        @(posedge clk); #1;
        bus.cmd_valid = 1'b1; bus.cmd_func = f; bus.cmd_len = l;
        t = cyc;
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
    endtask

    task automatic run(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk); #1;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk); #1;
        checks++;
        if (out_vec() !== 21'h100000) begin
            errors++; $display("FAIL reset_outputs: got %h expected %h", out_vec(), 21'h100000);
        end
        rst_n = 1'b1;
        run(1);
        checks++;
        if (out_vec() !== 21'h100000) begin
            errors++; $display("FAIL idle_outputs: got %h expected %h", out_vec(), 21'h100000);
        end
    endtask

    task automatic test_single_add();
        int t, bs, bw, bd;
        bs = n_start; bw = n_wb; bd = n_done;
        lat = 3; auto_en = 1'b1;
        send(1'b0, 6'd4, t);
        run(10);
        checks++; if (n_start - bs !== 1) begin errors++; $display("FAIL add_starts: got %0d expected 1", n_start - bs); end
        checks++; if (start_cyc[bs] !== t + 1) begin errors++; $display("FAIL add_start_cyc: got %0d expected %0d", start_cyc[bs], t + 1); end
        checks++; if (n_wb - bw !== 1) begin errors++; $display("FAIL add_wb_count: got %0d expected 1", n_wb - bw); end
        checks++; if (wb_cyc[bw] !== t + 5) begin errors++; $display("FAIL add_wb_cyc: got %0d expected %0d", wb_cyc[bw], t + 5); end
        checks++; if ({wb_grp_a[bw], wb_mask_a[bw], wb_func_a[bw]} !== {3'd0, 4'hF, 1'b0}) begin
            errors++; $display("FAIL add_wb_fields: got grp %0d mask %b func %b expected 0 1111 0", wb_grp_a[bw], wb_mask_a[bw], wb_func_a[bw]);
        end
        checks++; if (n_done - bd !== 1 || done_cyc !== t + 6) begin
            errors++; $display("FAIL add_done: got count %0d cyc %0d expected 1 at %0d", n_done - bd, done_cyc, t + 6);
        end
    endtask

    task automatic test_multi_group();
        int t, bs, bw, bd;
        logic [3:0] em [3];
        em = '{4'hF, 4'hF, 4'h3};
        bs = n_start; bw = n_wb; bd = n_done;
        lat = 2; auto_en = 1'b1;
        send(1'b1, 6'd10, t);
        run(20);
        checks++; if (n_start - bs !== 3) begin errors++; $display("FAIL mul_starts: got %0d expected 3", n_start - bs); end
        checks++; if (start_en[bs + 2] !== 4'h3) begin errors++; $display("FAIL mul_last_en: got %b expected 0011", start_en[bs + 2]); end
        checks++; if (n_wb - bw !== 3) begin errors++; $display("FAIL mul_wb_count: got %0d expected 3", n_wb - bw); end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({wb_grp_a[bw + i], wb_mask_a[bw + i], wb_func_a[bw + i]} !== {3'(i), em[i], 1'b1} || wb_cyc[bw + i] !== t + 4 + 4 * i) begin
                errors++; $display("FAIL mul_wb%0d: got grp %0d mask %b func %b cyc %0d expected %0d %b 1 %0d",
                    i, wb_grp_a[bw + i], wb_mask_a[bw + i], wb_func_a[bw + i], wb_cyc[bw + i], i, em[i], t + 4 + 4 * i);
            end
        end
        checks++; if (n_done - bd !== 1 || done_cyc !== t + 13) begin
            errors++; $display("FAIL mul_done: got count %0d cyc %0d expected 1 at %0d", n_done - bd, done_cyc, t + 13);
        end
    endtask

    task automatic test_staggered();
        int t, bw;
        bw = n_wb;
        auto_en = 1'b0;
        @(posedge clk); #1;
        bus.cmd_valid = 1'b1; bus.cmd_func = 1'b0; bus.cmd_len = 6'd4;
        t = cyc;
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        man_rdy = 4'hF;
        checks++; if (bus.lane_start !== 1'b1) begin errors++; $display("FAIL stag_issue: got %b expected 1", bus.lane_start); end
        @(posedge clk); #1; man_rdy = 4'b0001;
        @(posedge clk); #1; man_rdy = 4'b0100;
        @(posedge clk); #1; man_rdy = 4'b0010;
        @(posedge clk); #1; man_rdy = 4'b1000;
        @(posedge clk); #1; man_rdy = 4'b0000;
        run(4);
        checks++; if (n_wb - bw !== 1) begin errors++; $display("FAIL stag_wb_count: got %0d expected 1", n_wb - bw); end
        checks++; if (wb_cyc[bw] !== t + 6) begin errors++; $display("FAIL stag_wb_cyc: got %0d expected %0d", wb_cyc[bw], t + 6); end
        checks++; if (done_cyc !== t + 7) begin errors++; $display("FAIL stag_done_cyc: got %0d expected %0d", done_cyc, t + 7); end
    endtask

    task automatic test_len_zero();
        int t, bs, bw, bd;
        bs = n_start; bw = n_wb; bd = n_done;
        lat = 1; auto_en = 1'b1;
        send(1'b0, 6'd0, t);
        run(4);
        checks++; if (n_start - bs !== 0 || n_wb - bw !== 0) begin
            errors++; $display("FAIL zero_activity: got starts %0d wbs %0d expected 0 0", n_start - bs, n_wb - bw);
        end
        checks++; if (n_done - bd !== 1 || done_cyc !== t + 1) begin
            errors++; $display("FAIL zero_done: got count %0d cyc %0d expected 1 at %0d", n_done - bd, done_cyc, t + 1);
        end
    endtask

    task automatic test_len_clamp();
        int t, bs, bw, bd, be;
        bs = n_start; bw = n_wb; bd = n_done; be = n_err;
        lat = 1; auto_en = 1'b1;
        send(1'b0, 6'd40, t);
        run(30);
        checks++; if (n_err - be !== 1 || err_cyc !== t + 1) begin
            errors++; $display("FAIL clamp_err: got count %0d cyc %0d expected 1 at %0d", n_err - be, err_cyc, t + 1);
        end
        checks++; if (n_start - bs !== 8 || n_wb - bw !== 8) begin
            errors++; $display("FAIL clamp_groups: got starts %0d wbs %0d expected 8 8", n_start - bs, n_wb - bw);
        end
        checks++; if ({wb_grp_a[bw + 7], wb_mask_a[bw + 7]} !== {3'd7, 4'hF} || wb_cyc[bw + 7] !== t + 24) begin
            errors++; $display("FAIL clamp_last_wb: got grp %0d mask %b cyc %0d expected 7 1111 %0d", wb_grp_a[bw + 7], wb_mask_a[bw + 7], wb_cyc[bw + 7], t + 24);
        end
        checks++; if (n_done - bd !== 1 || done_cyc !== t + 25) begin
            errors++; $display("FAIL clamp_done: got count %0d cyc %0d expected 1 at %0d", n_done - bd, done_cyc, t + 25);
        end
    endtask

    task automatic test_abort_wait();
        int t, bw, bd, ba;
        bw = n_wb; bd = n_done; ba = n_abt;
        lat = 3; auto_en = 1'b1;
        send(1'b1, 6'd8, t);
        repeat (6) @(posedge clk); #1;
        checks++; if (bus.grp_idx !== 3'd1 || bus.lane_start !== 1'b0 || bus.lane_en !== 4'hF) begin
            errors++; $display("FAIL abtw_in_wait: got grp %0d start %b en %b expected 1 0 1111", bus.grp_idx, bus.lane_start, bus.lane_en);
        end
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        checks++; if ({aborted, bus.cmd_ready} !== 2'b11) begin
            errors++; $display("FAIL abtw_next: got aborted %b cmd_ready %b expected 1 1", aborted, bus.cmd_ready);
        end
        run(12);
        checks++; if (n_wb - bw !== 1 || n_done - bd !== 0) begin
            errors++; $display("FAIL abtw_after: got wbs %0d dones %0d expected 1 0", n_wb - bw, n_done - bd);
        end
        checks++; if (n_abt - ba !== 1 || abt_cyc !== t + 8) begin
            errors++; $display("FAIL abtw_pulse: got count %0d cyc %0d expected 1 at %0d", n_abt - ba, abt_cyc, t + 8);
        end
    endtask

    task automatic test_abort_write();
        int t, bw, bd, ba;
        bw = n_wb; bd = n_done; ba = n_abt;
        lat = 1; auto_en = 1'b1;
        send(1'b0, 6'd8, t);
        repeat (2) @(posedge clk); #1;
        checks++; if (bus.wb_valid !== 1'b1) begin errors++; $display("FAIL abtr_write: got %b expected 1", bus.wb_valid); end
        abort = 1'b1;
        #1;
        checks++; if (bus.wb_valid !== 1'b0) begin errors++; $display("FAIL abtr_suppress: got %b expected 0", bus.wb_valid); end
        @(posedge clk); #1;
        abort = 1'b0;
        run(6);
        checks++; if (n_wb - bw !== 0 || n_done - bd !== 0 || n_abt - ba !== 1) begin
            errors++; $display("FAIL abtr_after: got wbs %0d dones %0d aborts %0d expected 0 0 1", n_wb - bw, n_done - bd, n_abt - ba);
        end
    endtask

    task automatic test_async_reset();
        int t, bs, bw, bd;
        lat = 5; auto_en = 1'b1;
        send(1'b1, 6'd8, t);
        @(posedge clk); #1;
        #1 rst_n = 1'b0;
        #1;
        checks++; if (out_vec() !== 21'h100000) begin
            errors++; $display("FAIL areset_outputs: got %h expected %h", out_vec(), 21'h100000);
        end
        auto_en = 1'b0;
        #11 rst_n = 1'b1;
        auto_en = 1'b1; lat = 2;
        bs = n_start; bw = n_wb; bd = n_done;
        send(1'b0, 6'd4, t);
        run(8);
        checks++; if (n_start - bs !== 1 || start_grp[bs] !== 3'd0 || start_en[bs] !== 4'hF) begin
            errors++; $display("FAIL areset_start: got count %0d grp %0d en %b expected 1 0 1111", n_start - bs, start_grp[bs], start_en[bs]);
        end
        checks++; if (n_wb - bw !== 1 || {wb_grp_a[bw], wb_mask_a[bw], wb_func_a[bw]} !== {3'd0, 4'hF, 1'b0} || wb_cyc[bw] !== t + 4) begin
            errors++; $display("FAIL areset_wb: got count %0d grp %0d mask %b func %b cyc %0d expected 1 0 1111 0 %0d",
                n_wb - bw, wb_grp_a[bw], wb_mask_a[bw], wb_func_a[bw], wb_cyc[bw], t + 4);
        end
        checks++; if (n_done - bd !== 1 || done_cyc !== t + 5) begin
            errors++; $display("FAIL areset_done: got count %0d cyc %0d expected 1 at %0d", n_done - bd, done_cyc, t + 5);
        end
    endtask

    initial begin
        bus.cmd_valid = 1'b0;
        bus.cmd_func  = 1'b0;
        bus.cmd_len   = 6'd0;
        test_reset();
        test_single_add();
        test_multi_group();
        test_staggered();
        test_len_zero();
        test_len_clamp();
        test_abort_wait();
        test_abort_write();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
